// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared types and constants for the canal lock: the chamber level type,
// the level thresholds agreed with the lock controller, and the
// water-level responder state encoding.
// -----------------------------------------------------------------------------
package lock_pkg;

   // Level in tenths of a foot.
   typedef logic [5:0] level_t;

   localparam int unsigned LOCK_MAX_LEVEL   = 50;
   localparam int unsigned LOCK_HIGH_THRESH = 48;
   localparam int unsigned LOCK_LOW_THRESH  = 2;
   localparam int unsigned LOCK_LEVEL_INIT  = 0;

   typedef enum logic [1:0] {
      IDLE,
      FILLING,
      DRAINING
   } wl_state_t;

   // Clamp a configuration value into the representable level range.
   function automatic level_t clamp_level(input int unsigned value, input int unsigned ceiling);
      int unsigned w_lim;
      w_lim = (ceiling > 63) ? 63 : ceiling;
      return level_t'((value > w_lim) ? w_lim : value);
   endfunction

endpackage

// File: rtl/lock_water_level_if.sv
// -----------------------------------------------------------------------------
// lock_water_level_if
// Command/status bundle between the lock controller (master) and the
// water-level responder (slave).
//   fill_req, drain_req       : commands from the controller
//   gate_l_open, gate_r_open  : gate unlocked indications
//   level                     : current level, tenths of a foot
//   at_high, at_low           : threshold flags
//   busy, done, err           : command status
// -----------------------------------------------------------------------------
interface lock_water_level_if;
   import lock_pkg::*;

   logic   fill_req;
   logic   drain_req;
   logic   gate_l_open;
   logic   gate_r_open;
   level_t level;
   logic   at_high;
   logic   at_low;
   logic   busy;
   logic   done;
   logic   err;

   modport master (
      output fill_req, drain_req, gate_l_open, gate_r_open,
      input  level, at_high, at_low, busy, done, err
   );

   modport slave (
      input  fill_req, drain_req, gate_l_open, gate_r_open,
      output level, at_high, at_low, busy, done, err
   );

endinterface

// File: rtl/step_prescaler.sv
// -----------------------------------------------------------------------------
// step_prescaler
// Counts enabled cycles 0..TICKS_PER_STEP-1 and issues a one-cycle tick on
// the terminal count, wrapping back to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over enable)
//   i_en       : count enable
//   o_tick     : high during the enabled cycle at terminal count
// -----------------------------------------------------------------------------
module step_prescaler #(
   parameter int unsigned TICKS_PER_STEP = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   localparam int unsigned CntW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [CntW-1:0] Term = CntW'((TICKS_PER_STEP > 0) ? TICKS_PER_STEP - 1 : 0);

   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_d;
   logic            w_term;

   assign w_term = (r_cnt == Term);
   assign o_tick = i_en & ~i_clr & w_term;

   always_comb begin
      w_cnt_d = r_cnt;
      if (i_clr) begin
         w_cnt_d = '0;
      end else if (i_en) begin
         w_cnt_d = w_term ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

endmodule

// File: rtl/lock_water_level.sv
// -----------------------------------------------------------------------------
// lock_water_level
// Water-level responder for the canal lock. Accepts fill/drain commands in
// IDLE, steps the chamber level by one tenth of a foot every TICKS_PER_STEP
// cycles until the target threshold, and reports done/err pulses.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lock_water_level_if.slave (commands in, level/status out)
// at_high/at_low are combinational from the level register; all other
// outputs are registered.
// -----------------------------------------------------------------------------
module lock_water_level
   import lock_pkg::*;
#(
   parameter int unsigned TICKS_PER_STEP = 25_000_000,
   parameter int unsigned MAX_LEVEL      = LOCK_MAX_LEVEL,
   parameter int unsigned HIGH_THRESH    = LOCK_HIGH_THRESH,
   parameter int unsigned LOW_THRESH     = LOCK_LOW_THRESH,
   parameter int unsigned LEVEL_INIT     = LOCK_LEVEL_INIT
) (
   input  logic                clk,
   input  logic                rst_n,
   lock_water_level_if.slave   bus
);

   // Everything is clamped to MAX_LEVEL so a misconfigured threshold can
   // never push the level out of range; a fill then completes at MAX_LEVEL.
   localparam level_t MaxLvl  = clamp_level(MAX_LEVEL, 63);
   localparam level_t HighLvl = clamp_level(HIGH_THRESH, MAX_LEVEL);
   localparam level_t LowLvl  = clamp_level(LOW_THRESH, MAX_LEVEL);
   localparam level_t InitLvl = clamp_level(LEVEL_INIT, MAX_LEVEL);

   wl_state_t r_state, w_state_d;
   level_t    r_level, w_level_d;
   logic      r_busy, r_done, r_err;
   logic      w_done_d, w_err_d;
   logic      w_pre_clr, w_pre_en, w_tick;
   logic      w_gate, w_req;
   level_t    w_lvl_inc, w_lvl_dec;

   assign w_gate    = bus.gate_l_open | bus.gate_r_open;
   assign w_req     = bus.fill_req | bus.drain_req;
   assign w_lvl_inc = (r_level >= MaxLvl) ? MaxLvl : r_level + 6'd1;
   assign w_lvl_dec = (r_level == '0) ? '0 : r_level - 6'd1;

   step_prescaler #(
      .TICKS_PER_STEP (TICKS_PER_STEP)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_pre_clr),
      .i_en   (w_pre_en),
      .o_tick (w_tick)
   );

   always_comb begin
      w_state_d = r_state;
      w_level_d = r_level;
      w_done_d  = 1'b0;
      w_err_d   = 1'b0;
      w_pre_clr = 1'b1;
      w_pre_en  = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_req) begin
               if (w_gate || (bus.fill_req && bus.drain_req)) begin
                  w_err_d = 1'b1;
               end else if (bus.fill_req && (r_level >= HighLvl)) begin
                  w_done_d = 1'b1;
               end else if (bus.drain_req && (r_level <= LowLvl)) begin
                  w_done_d = 1'b1;
               end else if (bus.fill_req) begin
                  w_state_d = FILLING;
               end else begin
                  w_state_d = DRAINING;
               end
            end
         end

         FILLING: begin
            if (w_gate) begin
               // Abort: level holds, prescaler stays cleared.
               w_state_d = IDLE;
               w_err_d   = 1'b1;
            end else begin
               w_pre_clr = 1'b0;
               w_pre_en  = 1'b1;
               if (w_tick) begin
                  w_level_d = w_lvl_inc;
                  if ((w_lvl_inc >= HighLvl) || (w_lvl_inc == MaxLvl)) begin
                     w_state_d = IDLE;
                     w_done_d  = 1'b1;
                  end
               end
            end
         end

         DRAINING: begin
            if (w_gate) begin
               w_state_d = IDLE;
               w_err_d   = 1'b1;
            end else begin
               w_pre_clr = 1'b0;
               w_pre_en  = 1'b1;
               if (w_tick) begin
                  w_level_d = w_lvl_dec;
                  if ((w_lvl_dec <= LowLvl) || (w_lvl_dec == '0)) begin
                     w_state_d = IDLE;
                     w_done_d  = 1'b1;
                  end
               end
            end
         end

         default: begin
            w_state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_level <= InitLvl;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_level <= w_level_d;
         r_busy  <= (w_state_d != IDLE);
         r_done  <= w_done_d;
         r_err   <= w_err_d;
      end
   end

   assign bus.level   = r_level;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.err     = r_err;
   assign bus.at_high = (r_level >= HighLvl);
   assign bus.at_low  = (r_level <= LowLvl);

endmodule

// File: tb/tb_lock_water_level.sv
// -----------------------------------------------------------------------------
// tb_lock_water_level
// Directed scenarios followed by randomized commands and gate events, all
// compared every cycle against a behavioural model of the water-level rules.
// -----------------------------------------------------------------------------
module tb_lock_water_level;

   localparam int T    = 4;
   localparam int HIGH = 48;
   localparam int LOW  = 2;
   localparam int MAXL = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   lock_water_level_if bus ();

   lock_water_level #(
      .TICKS_PER_STEP (T),
      .MAX_LEVEL      (MAXL),
      .HIGH_THRESH    (HIGH),
      .LOW_THRESH     (LOW),
      .LEVEL_INIT     (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an active command remembers its start level and the
   // number of active cycles; the level is start +/- elapsed/T.
   int m_mode;    // 0 idle, 1 fill, 2 drain
   int m_start;
   int m_elapsed;
   int m_level;
   bit m_done;
   bit m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_start = 0; m_elapsed = 0; m_level = 0; m_done = 0; m_err = 0;
      end else begin
         bit gate;
         gate   = bus.gate_l_open || bus.gate_r_open;
         m_done = 0;
         m_err  = 0;
         if (m_mode == 0) begin
            if (bus.fill_req || bus.drain_req) begin
               if (gate || (bus.fill_req && bus.drain_req)) m_err = 1;
               else if (bus.fill_req && m_level >= HIGH)    m_done = 1;
               else if (bus.drain_req && m_level <= LOW)    m_done = 1;
               else begin
                  m_mode    = bus.fill_req ? 1 : 2;
                  m_start   = m_level;
                  m_elapsed = 0;
               end
            end
         end else if (gate) begin
            m_mode = 0;
            m_err  = 1;
         end else begin
            m_elapsed++;
            if (m_mode == 1) begin
               m_level = m_start + m_elapsed / T;
               if (m_level > MAXL) m_level = MAXL;
               if (m_level >= HIGH) begin m_mode = 0; m_done = 1; end
            end else begin
               m_level = m_start - m_elapsed / T;
               if (m_level < 0) m_level = 0;
               if (m_level <= LOW) begin m_mode = 0; m_done = 1; end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("level",   bus.level,   m_level);
      check("busy",    bus.busy,    m_mode != 0);
      check("done",    bus.done,    m_done);
      check("err",     bus.err,     m_err);
      check("at_high", bus.at_high, m_level >= HIGH);
      check("at_low",  bus.at_low,  m_level <= LOW);
      check("done_err_exclusive", bus.done & bus.err, 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_cmd(input bit f, input bit d);
      bus.fill_req  = f;
      bus.drain_req = d;
      step();
      bus.fill_req  = 1'b0;
      bus.drain_req = 1'b0;
   endtask

   // Cycles from the current point until done is seen; 0 on timeout.
   task automatic wait_done(input int budget, output int n);
      n = 0;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (bus.done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_level(input int lvl, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (int'(bus.level) == lvl) begin
            ok = 1;
            break;
         end
      end
   endtask

   initial begin
      int n;
      bit ok;
      bus.fill_req    = 1'b0;
      bus.drain_req   = 1'b0;
      bus.gate_l_open = 1'b0;
      bus.gate_r_open = 1'b0;

      repeat (2) step();
      check("reset_level", bus.level, 0);
      check("reset_busy",  bus.busy,  0);
      rst_n = 1'b1;
      step();

      // Full fill from 0.
      pulse_cmd(1, 0);
      check("fill_busy_rise", bus.busy, 1);
      wait_done(250, n);
      check("fill_latency", n, 192);
      check("fill_level",   bus.level, 48);
      check("fill_at_high", bus.at_high, 1);
      check("fill_busy_end", bus.busy, 0);

      // Full drain from 48.
      pulse_cmd(0, 1);
      check("drain_busy_rise", bus.busy, 1);
      wait_done(250, n);
      check("drain_latency", n, 184);
      check("drain_level",   bus.level, 2);
      check("drain_at_low",  bus.at_low, 1);
      check("drain_at_high", bus.at_high, 0);

      // Conflicting requests.
      pulse_cmd(1, 1);
      check("both_err",   bus.err, 1);
      check("both_busy",  bus.busy, 0);
      check("both_level", bus.level, 2);
      step();
      check("both_err_end", bus.err, 0);

      // Abort a fill at level 10.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      pulse_cmd(1, 0);
      wait_level(10, 100, ok);
      check("abort_reach10", ok, 1);
      bus.gate_r_open = 1'b1;
      step();
      bus.gate_r_open = 1'b0;
      check("abort_err",   bus.err, 1);
      check("abort_busy",  bus.busy, 0);
      check("abort_level", bus.level, 10);
      repeat (20) begin
         step();
         check("abort_no_done", bus.done, 0);
      end
      check("abort_hold", bus.level, 10);

      // Refill to 48, then a fill request is already satisfied.
      pulse_cmd(1, 0);
      wait_done(250, n);
      check("refill_latency", n, 152);
      step();
      pulse_cmd(1, 0);
      check("sat_done",  bus.done, 1);
      check("sat_busy",  bus.busy, 0);
      check("sat_level", bus.level, 48);
      step();
      check("sat_busy_after", bus.busy, 0);

      // Asynchronous reset mid-drain at level 30.
      pulse_cmd(0, 1);
      wait_level(30, 150, ok);
      check("rst_reach30", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_level", bus.level, 0);
      check("arst_busy",  bus.busy, 0);
      check("arst_done",  bus.done, 0);
      check("arst_err",   bus.err, 0);
      step();
      rst_n = 1'b1;
      step();
      check("arst_idle_busy",  bus.busy, 0);
      check("arst_idle_level", bus.level, 0);

      // Randomized commands and occasional gate events.
      for (int i = 0; i < 4000; i++) begin
         bus.fill_req    = ($urandom_range(0, 7) == 0);
         bus.drain_req   = ($urandom_range(0, 7) == 0);
         bus.gate_l_open = ($urandom_range(0, 399) == 0);
         bus.gate_r_open = ($urandom_range(0, 399) == 0);
         step();
      end
      bus.fill_req    = 1'b0;
      bus.drain_req   = 1'b0;
      bus.gate_l_open = 1'b0;
      bus.gate_r_open = 1'b0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lock_water_level.md
Name: lock_water_level

Overview:
Water-level responder for the canal lock controller. It accepts fill and drain commands from the lock controller FSM and steps a chamber water-level counter at a fixed rate. It reports the level and the high/low threshold flags that the controller uses to unlock the gates, and signals completion or rejection of each command. It sits beside the controller in the lock top level and drives the level display.

Parameters:
- TICKS_PER_STEP, 25_000_000: clock cycles per 0.1 ft level change (0.5 s at 50 MHz).
- MAX_LEVEL, 50: maximum level in tenths of a foot.
- HIGH_THRESH, 48: fill target; at_high when level >= 48 (>4.7 ft).
- LOW_THRESH, 2: drain target; at_low when level <= 2 (<0.3 ft).
- LEVEL_INIT, 0: level loaded on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fill_req  in  1  controller requests fill to HIGH_THRESH; sampled only in IDLE
- drain_req  in  1  controller requests drain to LOW_THRESH; sampled only in IDLE
- gate_l_open  in  1  left gate unlocked
- gate_r_open  in  1  right gate unlocked
- level  out  6  current level in tenths of a foot
- at_high  out  1  level >= HIGH_THRESH
- at_low  out  1  level <= LOW_THRESH
- busy  out  1  high while in FILLING or DRAINING
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse when a command is rejected or aborted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, level=LEVEL_INIT, prescaler=0, busy=0, done=0, err=0.
  - Reset overrides any operation in progress.
- at_high and at_low are combinational from the registered level. All other outputs are registered.
- State IDLE. Requests are evaluated in this priority order:
  - gate_l_open|gate_r_open with any request: err pulse next cycle; stay IDLE.
  - fill_req & drain_req: err pulse; stay IDLE; level unchanged.
  - fill_req, level already >= HIGH_THRESH: done pulse next cycle; no busy.
  - drain_req, level already <= LOW_THRESH: done pulse next cycle; no busy.
  - fill_req otherwise: go to FILLING; prescaler cleared; busy=1 the next cycle.
  - drain_req otherwise: go to DRAINING; prescaler cleared; busy=1 the next cycle.
- State FILLING:
  - Prescaler counts 0..TICKS_PER_STEP-1. At terminal count, level+1 and prescaler wraps to 0.
  - When the incremented level equals HIGH_THRESH: go to IDLE; busy=0 and done=1 in the same cycle the new level appears.
- State DRAINING: mirror of FILLING, decrementing; completes at LOW_THRESH.
- Latency: (HIGH_THRESH−level)×TICKS_PER_STEP cycles from busy rising to done (fill); (level−LOW_THRESH)×TICKS_PER_STEP for drain.
- Abort: a gate open during FILLING or DRAINING forces IDLE on the next edge. err pulses, level holds its current value, no done, and the prescaler is cleared.
- Requests are ignored while busy, whether they change or deassert.
- Saturation: level never exceeds MAX_LEVEL and never drops below 0, regardless of parameter misuse.
- done and err are never asserted in the same cycle.

Decomposition:
- Package lock_pkg holds:
  - level_t (6-bit) and the threshold constants shared with the lock controller.
  - wl_state_t enum {IDLE, FILLING, DRAINING}.
- Sub-module step_prescaler: clear and enable inputs, one-cycle tick output every TICKS_PER_STEP enabled cycles, width $clog2(TICKS_PER_STEP).

Test Plan (TICKS_PER_STEP=4, LEVEL_INIT=0):
- Release reset, pulse fill_req with gates closed -> busy=1 next cycle; level increments every 4 cycles; done pulses exactly 192 cycles after busy rises; level=48, at_high=1, busy=0.
- From level 48, pulse drain_req -> done after 184 cycles; level=2, at_low=1, at_high=0.
- fill_req and drain_req together in IDLE at level 2 -> err pulses for 1 cycle; busy stays 0; level=2.
- Start fill from 0; raise gate_r_open when level=10 -> next cycle state IDLE, err=1, busy=0, level stays 10; no done ever.
- At level 48, pulse fill_req -> done pulses next cycle; busy never asserts; level unchanged.
- Drive reset=0 mid-drain at level 30, asynchronously between clock edges -> level=0, busy=0, done=0, err=0 immediately; IDLE after release.
